// File: rtl/pcm_to_i2s.sv
// -----------------------------------------------------------------------------
// pcm_to_i2s
//
// Transmit-side I2S serializer. It accepts one stereo PCM pair per frame over a
// valid/ready handshake. The pair is shifted out MSB-first on sd, with the usual
// I2S one-bit delay relative to ws. clk is the bit clock, so one serial bit is
// sent per cycle.
//
// A frame is 2*SLOT_BITS cycles long: the left slot (ws=0) comes first, then the
// right slot (ws=1). Each slot carries WORD_BITS data bits followed by zero
// padding.
//
// Ports:
//   clk          in   bit clock, rising-edge active
//   reset        in   synchronous, active-high
//   in_left      in   [WORD_BITS] left sample (two's complement, passed as-is)
//   in_right     in   [WORD_BITS] right sample
//   in_valid     in   pair on in_left/in_right is valid
//   in_ready     out  holding register empty; accept on in_valid && in_ready
//   ws           out  word select, 0 = left slot, 1 = right slot
//   sd           out  serial data
//   frame_start  out  high for the cycle with frame counter 0
//   underrun     out  one-cycle pulse: frame load found the holding register empty
// -----------------------------------------------------------------------------
module pcm_to_i2s #(
    parameter int WORD_BITS = 16,
    parameter int SLOT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] in_left,
    input  logic [WORD_BITS-1:0] in_right,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ws,
    output logic                 sd,
    output logic                 frame_start,
    output logic                 underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(FRAME_BITS - 2);
    localparam logic [CNT_W-1:0] CNT_SLOT     = CNT_W'(SLOT_BITS);

    // Frame position and registered outputs
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ws;
    logic                  r_sd;
    logic                  r_frame_start;
    logic                  r_underrun;

    // r_in_ready is also the "holding register empty" flag
    logic                  r_in_ready;
    logic [WORD_BITS-1:0]  r_hold_left;
    logic [WORD_BITS-1:0]  r_hold_right;

    // Frame shifter: MSB is the undelayed stream bit for the current cycle
    logic [FRAME_BITS-1:0] r_shift;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_full_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [FRAME_BITS-1:0] w_load_frame;

    assign w_accept   = in_valid && r_in_ready;
    assign w_load     = (r_cnt == CNT_LAST);
    assign w_cnt_next = w_load ? '0 : r_cnt + CNT_W'(1);

    // At the load edge a full holding register empties. It cannot be refilled
    // on that same edge, because in_ready is low while it is full. An empty
    // holding register may be filled on the load edge. That pair is not
    // forwarded; it waits for the next frame's load.
    assign w_full_next = w_accept || (!r_in_ready && !w_load);

    // Frame image: left word at the top of the left slot, right word at the top
    // of the right slot, zero padding elsewhere. All zeros on underrun.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        w_load_frame = '0;
        if (!r_in_ready) begin
            w_load_frame[FRAME_BITS-1 -: WORD_BITS] = r_hold_left;
            w_load_frame[SLOT_BITS-1  -: WORD_BITS] = r_hold_right;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_ws          <= 1'b0;
            r_sd          <= 1'b0;
            r_frame_start <= 1'b1;
            r_underrun    <= 1'b0;
            r_in_ready    <= 1'b1;
            r_shift       <= '0;
        end else begin
            r_cnt         <= w_cnt_next;
            // ws and frame_start are decoded from the next count so that, once
            // registered, they line up with the cycle r_cnt refers to.
            r_ws          <= (w_cnt_next >= CNT_SLOT);
            r_frame_start <= (w_cnt_next == '0);
            // underrun is visible during cycle F-1 when holding is empty at
            // the start of that cycle, i.e. right after this edge.
            r_underrun    <= (r_cnt == CNT_PRE_LAST) && !w_full_next;
            r_in_ready    <= !w_full_next;
            // Registering the shifter MSB gives the one-bit I2S delay.
            r_sd          <= r_shift[FRAME_BITS-1];
            if (w_load) begin
                r_shift <= w_load_frame;
            end else begin
                r_shift <= r_shift << 1;
            end
        end
    end

    // NOTE: holding data needs no reset; it is qualified by the empty flag and
    // only reaches the shifter when the flag says it is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_left  <= in_left;
            r_hold_right <= in_right;
        end
    end

    assign in_ready    = r_in_ready;
    assign ws          = r_ws;
    assign sd          = r_sd;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// -----------------------------------------------------------------------------
// tb_pcm_to_i2s
//
// Self-checking bench for pcm_to_i2s. It uses two instances: dut16
// (16-bit words in 16-bit slots) and dut24 (16-bit words in 24-bit slots).
//
// Stimulus pushes the expected content of each frame into a per-instance
// queue. Each entry holds the left/right words and whether underrun should
// pulse at the frame's last cycle. A negedge monitor deserializes sd (cnt 1 .. F-1
// plus cnt 0 of the next frame), pops the queue, and compares. It also checks
// ws, frame_start and idle underrun every cycle against a bench-side frame
// counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pcm_to_i2s;

    localparam int WB    = 16;
    localparam int SLOT0 = 16;
    localparam int SLOT1 = 24;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        tb_rst   [2];
    logic        tb_valid [2];
    logic [15:0] tb_l     [2];
    logic [15:0] tb_r     [2];

    logic rdy0, ws0, sd0, fs0, ur0;
    logic rdy1, ws1, sd1, fs1, ur1;

    pcm_to_i2s #(.WORD_BITS(WB), .SLOT_BITS(SLOT0)) dut16 (
        .clk(clk), .reset(tb_rst[0]),
        .in_left(tb_l[0]), .in_right(tb_r[0]), .in_valid(tb_valid[0]),
        .in_ready(rdy0), .ws(ws0), .sd(sd0), .frame_start(fs0), .underrun(ur0)
    );

    pcm_to_i2s #(.WORD_BITS(WB), .SLOT_BITS(SLOT1)) dut24 (
        .clk(clk), .reset(tb_rst[1]),
        .in_left(tb_l[1]), .in_right(tb_r[1]), .in_valid(tb_valid[1]),
        .in_ready(rdy1), .ws(ws1), .sd(sd1), .frame_start(fs1), .underrun(ur1)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int fbits(input int id);
        return (id == 0) ? 2 * SLOT0 : 2 * SLOT1;
    endfunction

    // Bench-side frame position, mirroring the counter behaviour of the block.
    int   s_cnt [2] = '{0, 0};
    int   s_frm [2] = '{0, 0};
    logic rst_q [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rst_q[i] <= tb_rst[i];
            if (tb_rst[i]) begin
                s_cnt[i] <= 0;
                s_frm[i] <= 0;
            end else if (s_cnt[i] == fbits(i) - 1) begin
                s_cnt[i] <= 0;
                s_frm[i] <= s_frm[i] + 1;
            end else begin
                s_cnt[i] <= s_cnt[i] + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [63:0] m_shift [2];
    bit          m_coll  [2] = '{1'b0, 1'b0};
    logic        m_ur    [2];

    task automatic mon_step(input int id, input logic sd, input logic ws, input logic fs,
                            input logic ur, input logic rdy);
        int          f;
        int          slot;
        int          c;
        bit          have;
        exp_t        e;
        logic [63:0] ef;
        f    = fbits(id);
        slot = f / 2;
        c    = s_cnt[id];
        if (rst_q[id]) begin
            check($sformatf("d%0d_rst_ws", id), ws, 1'b0);
            check($sformatf("d%0d_rst_sd", id), sd, 1'b0);
            check($sformatf("d%0d_rst_frame_start", id), fs, 1'b1);
            check($sformatf("d%0d_rst_underrun", id), ur, 1'b0);
            check($sformatf("d%0d_rst_in_ready", id), rdy, 1'b1);
            m_coll[id] = 1'b0;
            return;
        end
        check($sformatf("d%0d_ws@%0d", id, c), ws, (c >= slot));
        check($sformatf("d%0d_frame_start@%0d", id, c), fs, (c == 0));
        if (c != f - 1) check($sformatf("d%0d_underrun_idle@%0d", id, c), ur, 1'b0);
        else            m_ur[id] = ur;
        if (c == 1) begin
            m_shift[id] = {63'b0, sd};
            m_coll[id]  = 1'b1;
        end else if (m_coll[id]) begin
            m_shift[id] = {m_shift[id][62:0], sd};
            if (c == 0) begin
                m_coll[id] = 1'b0;
                have = 1'b1;
                e    = '0;
                if (id == 0) begin
                    if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
                end else begin
                    if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
                end
                if (!have) begin
                    check($sformatf("d%0d_unexpected_frame", id), m_shift[id], 64'hx);
                end else begin
                    // Expected stream bit at slot position p is word[15-p], zero past the word.
                    ef = '0;
                    for (int p = 0; p < f; p++) begin
                        logic [15:0] w;
                        int          pos;
                        w   = (p >= slot) ? e.r : e.l;
                        pos = p % slot;
                        ef[f-1-p] = (pos < WB) ? w[15-pos] : 1'b0;
                    end
                    check($sformatf("d%0d_frame_bits(L=%h R=%h)", id, e.l, e.r), m_shift[id], ef);
                    check($sformatf("d%0d_frame_underrun", id), m_ur[id], e.ur);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_step(0, sd0, ws0, fs0, ur0, rdy0);
            mon_step(1, sd1, ws1, fs1, ur1, rdy1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int id, input int frm, input int c);
        int n;
        n = 0;
        while (!(s_frm[id] == frm && s_cnt[id] == c)) begin
            if (n > 400) begin
                check($sformatf("d%0d_goto_timeout(%0d,%0d)", id, frm, c), 1, 0);
                return;
            end
            n++;
            tick();
        end
    endtask

    task automatic push(input int id, input logic [15:0] l, input logic [15:0] r, input logic ur);
        exp_t e;
        e.l  = l;
        e.r  = r;
        e.ur = ur;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic do_reset(input int id);
        check($sformatf("d%0d_queue_drained", id), (id == 0) ? q0.size() : q1.size(), 0);
        if (id == 0) q0.delete();
        else         q1.delete();
        tb_valid[id] = 1'b0;
        tb_rst[id]   = 1'b1;
        tick();
        check($sformatf("d%0d_in_ready_in_reset", id), (id == 0) ? rdy0 : rdy1, 1'b1);
        tick();
        tick();
        tb_rst[id] = 1'b0;
    endtask

    // Present a pair and hold in_valid until it is taken. Returns the frame and
    // counter position of the accepting cycle.
    task automatic send(input int id, input logic [15:0] l, input logic [15:0] r,
                        output int af, output int ac);
        int n;
        tb_l[id]     = l;
        tb_r[id]     = r;
        tb_valid[id] = 1'b1;
        n = 0;
        while (((id == 0) ? rdy0 : rdy1) !== 1'b1) begin
            if (n > 200) begin
                check($sformatf("d%0d_accept_timeout", id), 0, 1);
                break;
            end
            n++;
            tick();
        end
        af = s_frm[id];
        ac = s_cnt[id];
        tick();
        tb_valid[id] = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int af;
        int ac;
        for (int i = 0; i < 2; i++) begin
            tb_rst[i]   = 1'b1;
            tb_valid[i] = 1'b0;
            tb_l[i]     = '0;
            tb_r[i]     = '0;
        end
        tick();
        mon_on = 1'b1;

        // Reset and idle: three all-zero frames, each ending with underrun.
        do_reset(0);
        push(0, 16'h0000, 16'h0000, 1'b1);
        push(0, 16'h0000, 16'h0000, 1'b1);
        push(0, 16'h0000, 16'h0000, 1'b1);
        goto(0, 3, 2);

        // Basic pair accepted at cnt 5 of frame 0.
        do_reset(0);
        push(0, 16'h0000, 16'h0000, 1'b0);
        push(0, 16'h8001, 16'h7FFE, 1'b1);
        goto(0, 0, 5);
        send(0, 16'h8001, 16'h7FFE, af, ac);
        check("basic_accept_pos", {af[15:0], ac[15:0]}, {16'd0, 16'd5});
        check("basic_ready_low_cnt6", rdy0, 1'b0);
        goto(0, 0, 31);
        check("basic_ready_low_cnt31", rdy0, 1'b0);
        check("basic_no_underrun_cnt31", ur0, 1'b0);
        goto(0, 1, 0);
        check("basic_ready_back_f1c0", rdy0, 1'b1);
        goto(0, 1, 1);
        check("basic_left_msb_f1c1", sd0, 1'b1);
        goto(0, 1, 16);
        check("basic_left_lsb_f1c16", {ws0, sd0}, 2'b11);
        goto(0, 2, 2);

        // Backpressure: A taken at cnt 3, B waits for cnt 0 of frame 1.
        do_reset(0);
        push(0, 16'h0000, 16'h0000, 1'b0);
        push(0, 16'h1234, 16'hABCD, 1'b0);
        push(0, 16'hFEDC, 16'h0F0F, 1'b1);
        goto(0, 0, 3);
        send(0, 16'h1234, 16'hABCD, af, ac);
        check("bp_accept_a_pos", {af[15:0], ac[15:0]}, {16'd0, 16'd3});
        send(0, 16'hFEDC, 16'h0F0F, af, ac);
        check("bp_accept_b_pos", {af[15:0], ac[15:0]}, {16'd1, 16'd0});
        goto(0, 3, 2);

        // Edge acceptance at cnt 31: underrun, zero frame 1, pair in frame 2.
        do_reset(0);
        push(0, 16'h0000, 16'h0000, 1'b1);
        push(0, 16'h0000, 16'h0000, 1'b0);
        push(0, 16'h5A5A, 16'hC3C3, 1'b1);
        goto(0, 0, 31);
        check("edge_underrun_cnt31", ur0, 1'b1);
        send(0, 16'h5A5A, 16'hC3C3, af, ac);
        check("edge_accept_pos", {af[15:0], ac[15:0]}, {16'd0, 16'd31});
        check("edge_ready_held_f1c0", rdy0, 1'b0);
        goto(0, 3, 2);

        // Reset mid-frame: D in flight, E held, both discarded.
        do_reset(0);
        push(0, 16'h0000, 16'h0000, 1'b0);
        push(0, 16'h0000, 16'h0000, 1'b1);
        push(0, 16'h0000, 16'h0000, 1'b1);
        goto(0, 0, 2);
        send(0, 16'hFFFF, 16'h8000, af, ac);
        goto(0, 1, 3);
        send(0, 16'h1111, 16'h2222, af, ac);
        check("midrst_accept_e_pos", {af[15:0], ac[15:0]}, {16'd1, 16'd3});
        goto(0, 1, 10);
        check("midrst_data_in_flight", sd0, 1'b1);
        tb_rst[0] = 1'b1;
        tick();
        tb_rst[0] = 1'b0;
        check("midrst_outputs_after", {sd0, ws0, rdy0, fs0}, 4'b0011);
        goto(0, 2, 2);

        // Padding on the 24-bit-slot instance; the 16-bit one is parked in reset.
        check("d0_queue_drained_final", q0.size(), 0);
        tb_rst[0] = 1'b1;
        do_reset(1);
        push(1, 16'h0000, 16'h0000, 1'b0);
        push(1, 16'hA5A5, 16'h3C96, 1'b1);
        goto(1, 0, 4);
        send(1, 16'hA5A5, 16'h3C96, af, ac);
        goto(1, 1, 16);
        check("pad_left_lsb_c16", sd1, 1'b1);
        goto(1, 1, 17);
        check("pad_first_pad_c17", {ws1, sd1}, 2'b00);
        goto(1, 1, 25);
        check("pad_right_msb_c25", {ws1, sd1}, 2'b10);
        goto(1, 2, 2);
        check("d1_queue_drained_final", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcm_to_i2s.md
# pcm_to_i2s

Transmit-side I2S serializer: accepts one stereo PCM pair (left, right) per frame over a valid/ready handshake and shifts it out MSB-first on a single serial data line. It also drives the matching word-select. It sits at the output of the beamformer datapath and produces a stream that the team's I2S receiver decodes bit-exactly when clocked from the same `clk`. `clk` is the bit clock: one serial bit per cycle.

## Interface

Parameters:
- `WORD_BITS`, default 16: PCM sample width per channel. Two's complement, passed through unmodified.
- `SLOT_BITS`, default 16: clk cycles per channel slot. Must be ≥ `WORD_BITS`. Frame length F = 2·`SLOT_BITS`.

Ports:
- `clk`, in, 1: bit clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_left`, in, `WORD_BITS`: left sample.
- `in_right`, in, `WORD_BITS`: right sample.
- `in_valid`, in, 1: pair on `in_left`/`in_right` is valid.
- `in_ready`, out, 1: holding register empty; pair accepted when `in_valid && in_ready` at a rising edge.
- `ws`, out, 1: word select; 0 = left slot, 1 = right slot.
- `sd`, out, 1: serial data.
- `frame_start`, out, 1: one-cycle pulse, high while frame counter = 0.
- `underrun`, out, 1: one-cycle pulse; frame load found holding register empty.

## Operation

- Frame counter `cnt`, range 0..F-1, increments every cycle and wraps F-1 → 0.
- `ws` = 0 for `cnt` < `SLOT_BITS`, 1 otherwise. `frame_start` = (`cnt` == 0).
- Holding register: one pair plus full flag.
  - `in_ready` = !full.
  - Accept sets full and captures both words.
- Frame shifter: holds the pair currently transmitted.
- Load at the cycle with `cnt` == F-1:
  - If full at the start of that cycle, the shifter takes the holding pair and full clears. `in_ready` is 1 in the next cycle (`cnt` = 0).
  - If empty, the shifter loads zeros and `underrun` pulses in that cycle.
  - A pair accepted in that same cycle is not forwarded. It waits in holding for the next frame's load.
- Undelayed stream u at slot position p = `cnt` mod `SLOT_BITS`:
  - For p < `WORD_BITS`: bit [`WORD_BITS`-1-p] of the slot's word (left word in the left slot, right word in the right slot).
  - For p ≥ `WORD_BITS`: 0 (padding).
- `sd` is u delayed by exactly one clk (I2S one-bit delay):
  - MSB of a slot appears one cycle after the `ws` transition.
  - When `SLOT_BITS` == `WORD_BITS`, the LSB of a slot appears in the first cycle of the following slot, with `ws` already toggled.
  - The right-channel LSB therefore lands at `cnt` = 0 of the next frame.
- No arithmetic on samples. Sign, width and bit order are preserved exactly.

## Timing

- Reset values, held every cycle reset is high:
  - `cnt`=0, `ws`=0, `sd`=0, `frame_start`=1, `underrun`=0, `in_ready`=1.
  - Holding empty, shifter zero, delay flop zero.
- Reset releases into `cnt`=0. Frame 0 transmits all zeros.
- Reset mid-frame aborts transmission immediately. Held and in-flight data are discarded, and outputs take reset values in the cycle after reset is sampled.
- Latency:
  - A pair accepted at any cycle of frame k with `cnt` ≤ F-2, holding empty, transmits in frame k+1.
  - Left MSB on `sd` at `cnt`=1 of frame k+1; right MSB at `cnt`=`SLOT_BITS`+1.
- Throughput: one pair per F cycles. At most one pair is buffered beyond the shifter.
- While `in_ready`=0, `in_valid` may stay high; inputs are ignored until acceptance.
- `sd`, `ws`, `frame_start`, `underrun` and `in_ready` are all registered outputs; no combinational path from inputs.

## Test plan

- **Reset:** hold `reset` 3 cycles, release, hold `in_valid`=0.
  - During reset: `ws`=0, `sd`=0, `in_ready`=1.
  - After release: `sd`=0 for 32 cycles; `ws` high exactly at `cnt` 16..31; `frame_start` at `cnt` 0, 32, 64.
  - `underrun` pulses at `cnt` 31, 63, ...
- **Basic pair (16/16):** accept L=0x8001, R=0x7FFE at `cnt`=5 of frame 0.
  - `in_ready`=0 from `cnt` 6 until `cnt`=0 of frame 1; no `underrun` at `cnt` 31.
  - Frame 1: `sd`=1 at `cnt` 1; 0 at `cnt` 2..15; 1 at `cnt` 16 (L LSB, `ws`=1); 0 at `cnt` 17; 1 at `cnt` 18..31.
  - Frame 2: `sd`=0 at `cnt` 0 (R LSB).
- **Backpressure:** `in_valid` held high with pairs A then B from frame 0, `cnt` 3.
  - A accepted at `cnt` 3; B held with `in_ready`=0 until `cnt`=0 of frame 1, accepted there.
  - A transmits in frame 1, B in frame 2, no `underrun`.
- **Edge acceptance:** accept a pair exactly at `cnt`=31 with holding empty.
  - `underrun` pulses at that cycle; frame 1 is all zeros; the pair transmits in frame 2.
- **Reset mid-frame:** load L=0xFFFF, assert reset at frame 1 `cnt`=10 for 1 cycle.
  - `sd`=0, `ws`=0, `in_ready`=1 the next cycle.
  - Following frame all zeros; the held pair is lost.
- **Padding (`WORD_BITS`=16, `SLOT_BITS`=24):** send L=0xA5A5.
  - `ws` period 48 cycles.
  - `sd` at `cnt` 1..16 = 1010010110100101; `sd` = 0 at `cnt` 17..24.
  - R bits follow from `cnt` 25.
